// File: rtl/audio_pkg.sv
// Types and constants shared by the sample-memory audio player and recorder.
package audio_pkg;

    localparam int unsigned DefClockRate  = 400_000;
    localparam int unsigned DefSampleRate = 16_000;
    localparam int unsigned DefAddrWidth  = 14;
    localparam int unsigned SampleWidth   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRec,
        StFull
    } rec_state_e;

    // Map a window ones count (0..w) onto 0..255 with round-to-nearest.
    function automatic logic [SampleWidth-1:0] pcm_scale(input int unsigned ones,
                                                         input int unsigned w);
        int unsigned scaled;
        scaled = (ones * (32'd65280 / w) + 32'd128) >> 8;
        return (scaled > 32'd255) ? 8'd255 : scaled[SampleWidth-1:0];
    endfunction

endpackage

// File: rtl/audio_recorder_if.sv
// Valid/ready write port into sample memory.
interface audio_recorder_if
    import audio_pkg::*;
#(
    parameter int unsigned AddrWidth = DefAddrWidth
) ();

    logic                   wr_valid;
    logic                   wr_ready;
    logic [AddrWidth-1:0]   wr_addr;
    logic [SampleWidth-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/pdm_decimator.sv
// PDM synchronizer plus boxcar ones-counter; emits one scaled PCM sample per window.
module pdm_decimator
    import audio_pkg::*;
#(
    parameter int unsigned Window = DefClockRate / DefSampleRate
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   pdm_i,
    output logic [SampleWidth-1:0] sample_o,
    output logic                   sample_stb_o
);

    localparam int unsigned     CntW    = $clog2(Window);
    localparam int unsigned     AccW    = $clog2(Window + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(Window - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [AccW-1:0] ones;
    logic            win_end;

    // Counter and accumulator sit at zero whenever not enabled, so a new window
    // always starts clean and a stopped one is simply forgotten.
    always_comb begin
        ones    = acc_q + AccW'(sync_q[1]);
        win_end = en_i && (cnt_q == LastCnt);
        cnt_d   = '0;
        acc_d   = '0;
        if (en_i && !win_end) begin
            cnt_d = cnt_q + CntW'(1);
            acc_d = ones;
        end
    end

    assign sample_o     = pcm_scale(32'(ones), Window);
    assign sample_stb_o = win_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pdm_i};
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/audio_recorder.sv
// Records decimated PDM audio into sample memory until stopped or memory is full.
module audio_recorder
    import audio_pkg::*;
#(
    parameter int unsigned ClockRate  = DefClockRate,
    parameter int unsigned SampleRate = DefSampleRate,
    parameter int unsigned AddrWidth  = DefAddrWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 pdm_i,
    audio_recorder_if.master     wr,
    output logic                 recording_o,
    output logic                 done_o,
    output logic                 overrun_o,
    output logic [AddrWidth:0]   rec_len_o
);

    localparam int unsigned          Window   = ClockRate / SampleRate;
    localparam logic [AddrWidth-1:0] LastAddr = '1;

    rec_state_e             state_q, state_d;
    logic                   valid_q, valid_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [SampleWidth-1:0] data_q, data_d;
    logic [AddrWidth:0]     len_q, len_d;
    logic                   over_q, over_d;
    logic                   rec_q, done_q;
    logic                   xfer;
    logic                   sample_stb;
    logic [SampleWidth-1:0] sample;

    pdm_decimator #(
        .Window(Window)
    ) u_decim (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == StRec),
        .pdm_i       (pdm_i),
        .sample_o    (sample),
        .sample_stb_o(sample_stb)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        len_d   = len_q;
        over_d  = over_q;
        xfer    = valid_q && wr.wr_ready;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (enable_i) begin
                    state_d = StRec;
                    addr_d  = '0;
                    len_d   = '0;
                    over_d  = 1'b0;
                end
            end
            StRec: begin
                if (xfer) begin
                    addr_d  = addr_q + AddrWidth'(1);
                    len_d   = len_q + (AddrWidth + 1)'(1);
                    valid_d = 1'b0;
                end
                if (!enable_i) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end else if (xfer && (addr_q == LastAddr)) begin
                    state_d = StFull;
                end else if (sample_stb) begin
                    // Holding register frees up in the same cycle it transfers.
                    if (!valid_q || xfer) begin
                        data_d  = sample;
                        valid_d = 1'b1;
                    end else begin
                        over_d = 1'b1;
                    end
                end
            end
            StFull: begin
                valid_d = 1'b0;
                if (!enable_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            len_q   <= '0;
            over_q  <= 1'b0;
            rec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            len_q   <= len_d;
            over_q  <= over_d;
            rec_q   <= (state_d == StRec);
            done_q  <= (state_d == StFull);
        end
    end

    assign wr.wr_valid  = valid_q;
    assign wr.wr_addr   = addr_q;
    assign wr.wr_data   = data_q;
    assign recording_o  = rec_q;
    assign done_o       = done_q;
    assign overrun_o    = over_q;
    assign rec_len_o    = len_q;

endmodule

// File: tb/tb_audio_recorder.sv
// Bench for audio_recorder: pattern table, directed corner cases, random run vs. model.
module tb_audio_recorder;
    import audio_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned Depth = 1 << AW;
    localparam int unsigned W     = DefClockRate / DefSampleRate;
    localparam int unsigned Scale = 65280 / W;

    logic        clk = 1'b0;
    logic        rst, enable, pdm, ready;
    logic        recording, done, overrun;
    logic [AW:0] rec_len;

    audio_recorder_if #(.AddrWidth(AW)) wr_if ();
    assign wr_if.wr_ready = ready;

    audio_recorder #(.AddrWidth(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (enable),
        .pdm_i      (pdm),
        .wr         (wr_if),
        .recording_o(recording),
        .done_o     (done),
        .overrun_o  (overrun),
        .rec_len_o  (rec_len)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // pdm source: pat_p == 0 means random with pat_k percent ones density
    int pat_p = 1, pat_k = 1, ph = 0;

    // Reference model state
    int          m_mode;   // 0 idle, 1 recording, 2 full
    bit          m_hist[$];
    bit          m_win[$];
    bit          m_valid, m_over;
    int          m_addr, m_len;
    byte unsigned m_data;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit p, input bit rdy);
        bit          synced, stb, xfer;
        int          ones;
        int unsigned smp;
        if (r) begin
            m_mode = 0; m_hist = '{0, 0}; m_win.delete();
            m_valid = 0; m_over = 0; m_addr = 0; m_len = 0; m_data = 0;
            return;
        end
        synced = m_hist.pop_front();
        m_hist.push_back(p);
        stb = 0;
        smp = 0;
        if (m_mode == 1) begin
            m_win.push_back(synced);
            if (m_win.size() == W) begin
                ones = 0;
                foreach (m_win[i]) ones += int'(m_win[i]);
                smp = (ones * Scale + 128) / 256;
                if (smp > 255) smp = 255;
                stb = 1;
                m_win.delete();
            end
        end else begin
            m_win.delete();
        end
        xfer = m_valid && rdy;
        case (m_mode)
            0: begin
                m_valid = 0;
                if (en) begin m_mode = 1; m_addr = 0; m_len = 0; m_over = 0; end
            end
            1: begin
                bit last;
                last = (m_addr == Depth - 1);
                if (xfer) begin m_addr = (m_addr + 1) % Depth; m_len++; m_valid = 0; end
                if (!en) begin
                    m_mode = 0; m_valid = 0;
                end else if (xfer && last) begin
                    m_mode = 2;
                end else if (stb) begin
                    if (!m_valid) begin m_data = 8'(smp); m_valid = 1; end
                    else m_over = 1;
                end
            end
            default: begin
                m_valid = 0;
                if (!en) m_mode = 0;
            end
        endcase
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data, recording, done, overrun,
                    rec_len});
    endfunction

    function automatic logic [63:0] model_vec();
        return 64'({m_valid, AW'(m_addr), m_data, (m_mode == 1), (m_mode == 2), m_over,
                    (AW + 1)'(m_len)});
    endfunction

    task automatic tick();
        if (pat_p == 0) pdm = ($urandom_range(99) < pat_k);
        else pdm = ((ph % pat_p) < pat_k);
        ph++;
        @(posedge clk);
        #1;
        model_step(rst, enable, pdm, ready);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (wr_if.wr_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("valid_timeout", 64'(wr_if.wr_valid), 64'd1);
    endtask

    task automatic restart(input int p, input int k);
        pat_p = p; pat_k = k;
        rst = 1'b1; enable = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    typedef struct {
        int    p;
        int    k;
        int    e0;
        int    e1;
        bit    tog;
        string name;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n, prev, got, exp, cnt;

        tbl[0] = '{1, 0, 0,   0,   1'b0, "all_zero"};
        tbl[1] = '{1, 1, 255, 255, 1'b0, "all_one"};
        tbl[2] = '{2, 1, 133, 122, 1'b1, "alternate"};
        tbl[3] = '{5, 1, 51,  51,  1'b0, "one_in_five"};
        tbl[4] = '{5, 4, 204, 204, 1'b0, "four_in_five"};

        rst = 1'b1; enable = 1'b0; ready = 1'b1;
        tick();
        tick();
        check("reset_state", dut_vec(), 64'd0);
        rst = 1'b0;

        // First-sample latency and write cadence with a constant-1 stream
        repeat (4) tick();
        enable = 1'b1;
        tick();
        wait_valid(100, n);
        check("first_latency", 64'(n), 64'd25);
        check("first_data", 64'(wr_if.wr_data), 64'd255);
        check("first_addr", 64'(wr_if.wr_addr), 64'd0);
        tick();
        wait_valid(100, n);
        check("write_period", 64'(n + 1), 64'd25);
        check("second_addr", 64'(wr_if.wr_addr), 64'd1);
        check("second_len", 64'(rec_len), 64'd1);
        check("no_overrun", 64'(overrun), 64'd0);

        // Pattern table
        foreach (tbl[t]) begin
            restart(tbl[t].p, tbl[t].k);
            enable = 1'b1;
            tick();
            prev = -1;
            for (int s = 0; s < 4; s++) begin
                wait_valid(60, n);
                got = int'(wr_if.wr_data);
                if (!tbl[t].tog) exp = tbl[t].e0;
                else if (prev < 0) exp = (got == tbl[t].e1) ? tbl[t].e1 : tbl[t].e0;
                else exp = (prev == tbl[t].e0) ? tbl[t].e1 : tbl[t].e0;
                check(tbl[t].name, 64'(got), 64'(exp));
                check("table_addr", 64'(wr_if.wr_addr), 64'(s));
                prev = got;
                tick();
            end
        end

        // Back-pressure: hold the first sample for 60 cycles
        restart(1, 1);
        ready = 1'b0;
        enable = 1'b1;
        tick();
        wait_valid(100, n);
        for (int i = 1; i <= 60; i++) begin
            tick();
            check("hold_addr", 64'(wr_if.wr_addr), 64'd0);
            check("hold_data", 64'(wr_if.wr_data), 64'd255);
            if (i == 24) check("overrun_early", 64'(overrun), 64'd0);
            if (i == 25) check("overrun_set", 64'(overrun), 64'd1);
        end
        ready = 1'b1;
        tick();
        check("held_written_len", 64'(rec_len), 64'd1);
        check("held_written_addr", 64'(wr_if.wr_addr), 64'd1);
        check("overrun_sticky", 64'(overrun), 64'd1);

        // Fill memory
        restart(1, 1);
        enable = 1'b1;
        tick();
        cnt = 0; n = 0;
        while (done !== 1'b1 && n < Depth * W + 100) begin
            if (wr_if.wr_valid === 1'b1) begin
                check("full_addr_seq", 64'(wr_if.wr_addr), 64'(cnt));
                cnt++;
            end
            tick();
            n++;
        end
        check("full_done", 64'(done), 64'd1);
        check("full_writes", 64'(cnt), 64'(Depth));
        check("full_len", 64'(rec_len), 64'(Depth));
        check("full_not_rec", 64'(recording), 64'd0);
        cnt = 0;
        repeat (60) begin
            tick();
            if (wr_if.wr_valid === 1'b1) cnt++;
        end
        check("full_no_writes", 64'(cnt), 64'd0);
        enable = 1'b0;
        tick();
        check("done_clears", 64'(done), 64'd0);

        // Stop mid-window during the fourth sample
        restart(1, 1);
        enable = 1'b1;
        tick();
        repeat (3) begin
            wait_valid(60, n);
            tick();
        end
        repeat (9) tick();
        enable = 1'b0;
        tick();
        check("stop_not_rec", 64'(recording), 64'd0);
        cnt = 0;
        repeat (40) begin
            tick();
            if (wr_if.wr_valid === 1'b1) cnt++;
        end
        check("stop_no_partial", 64'(cnt), 64'd0);
        check("stop_len", 64'(rec_len), 64'd3);
        enable = 1'b1;
        tick();
        wait_valid(60, n);
        check("restart_addr", 64'(wr_if.wr_addr), 64'd0);

        // Reset while a write is pending
        ready = 1'b0;
        tick();
        wait_valid(60, n);
        rst = 1'b1;
        tick();
        check("rst_midwrite", dut_vec(), 64'd0);
        rst = 1'b0;
        enable = 1'b0;
        tick();
        check("rst_idle", 64'({recording, wr_if.wr_valid}), 64'd0);

        // Randomized run against the model
        restart(0, 50);
        enable = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (i % 200 == 0) pat_k = $urandom_range(100);
            ready = ($urandom_range(99) < ((i / 500) % 2 == 0 ? 90 : 40));
            if (enable && $urandom_range(299) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(9) == 0) enable = 1'b1;
            rst = ($urandom_range(2999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
